// File: rtl/thd_pkg.sv
// Shared types and encodings for the thread scheduler.
package thd_pkg;

    localparam int NUM_THD_DEF = 8;

    // Per-thread lifecycle state.
    typedef enum logic [1:0] {
        FREE  = 2'b00,
        READY = 2'b01,
        SLEEP = 2'b10
    } thd_state_e;

    // trd_ctrl encodings as produced by the decoder.
    localparam logic [1:0] TRD_NONE  = 2'b00;
    localparam logic [1:0] TRD_SLEEP = 2'b01;
    localparam logic [1:0] TRD_WAKE  = 2'b10;
    localparam logic [1:0] TRD_KILL  = 2'b11;

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester strictly after ptr, wrapping; ptr itself last.
module rr_arbiter #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] idx;

    // Scan ptr+1 .. ptr+N; N is a power of two so the W-bit add wraps for free.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int i = 1; i <= N; i++) begin
            idx = ptr + W'(i);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Per-thread state table plus round-robin issue selection among READY threads.
module thread_scheduler
    import thd_pkg::*;
#(
    parameter int NUM_THD = NUM_THD_DEF,
    parameter int TID_W   = $clog2(NUM_THD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             cmd_vld,
    input  logic [TID_W-1:0] cmd_tid,
    input  logic [1:0]       trd_ctrl,
    input  logic             init,
    input  logic [TID_W-1:0] tgt_tid,
    input  logic [31:0]      init_pc,
    output logic             issue_vld,
    output logic [TID_W-1:0] issue_tid,
    output logic             init_ok,
    output logic [TID_W-1:0] init_tid,
    output logic             new_vld,
    output logic [TID_W-1:0] new_tid,
    output logic [31:0]      new_pc,
    output logic             cmd_err,
    output logic             all_idle
);

    thd_state_e       state_q [NUM_THD];
    thd_state_e       state_d [NUM_THD];
    logic [TID_W-1:0] ptr_q, ptr_d;
    logic             new_vld_q, new_vld_d;
    logic [TID_W-1:0] new_tid_q, new_tid_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic             cmd_err_q, cmd_err_d;

    logic [NUM_THD-1:0] ready;
    logic               any_live;
    logic               free_found;
    logic [TID_W-1:0]   free_idx;

    // Occupancy summaries of the state table.
    always_comb begin
        ready    = '0;
        any_live = 1'b0;
        for (int i = 0; i < NUM_THD; i++) begin
            ready[i] = (state_q[i] == READY);
            if (state_q[i] != FREE) any_live = 1'b1;
        end
    end

    // Lowest-indexed FREE slot: scan downward so the last hit is the lowest.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_THD - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                free_found = 1'b1;
                free_idx   = TID_W'(i);
            end
        end
    end

    rr_arbiter #(.N(NUM_THD), .W(TID_W)) u_arb (
        .req     (ready),
        .ptr     (ptr_q),
        .gnt_vld (issue_vld),
        .gnt_idx (issue_tid)
    );

    assign init_ok  = cmd_vld & init & (trd_ctrl == TRD_NONE) & free_found;
    assign init_tid = free_idx;
    assign all_idle = ~any_live;
    assign new_vld  = new_vld_q;
    assign new_tid  = new_tid_q;
    assign new_pc   = new_pc_q;
    assign cmd_err  = cmd_err_q;

    // Command decode: each command touches at most its single subject thread.
    always_comb begin
        state_d   = state_q;
        ptr_d     = (issue_vld && !stall) ? issue_tid : ptr_q;
        new_vld_d = 1'b0;
        new_tid_d = new_tid_q;
        new_pc_d  = new_pc_q;
        cmd_err_d = 1'b0;
        if (cmd_vld) begin
            if (init && trd_ctrl != TRD_NONE) begin
                cmd_err_d = 1'b1;
            end else if (init) begin
                if (free_found) begin
                    state_d[free_idx] = READY;
                    new_vld_d         = 1'b1;
                    new_tid_d         = free_idx;
                    new_pc_d          = init_pc;
                end else begin
                    cmd_err_d = 1'b1;
                end
            end else begin
                case (trd_ctrl)
                    TRD_SLEEP: begin
                        if (state_q[cmd_tid] == READY) state_d[cmd_tid] = SLEEP;
                        else                           cmd_err_d        = 1'b1;
                    end
                    TRD_WAKE: begin
                        // Waking an already READY thread is a harmless no-op.
                        if (state_q[tgt_tid] == SLEEP)      state_d[tgt_tid] = READY;
                        else if (state_q[tgt_tid] != READY) cmd_err_d        = 1'b1;
                    end
                    TRD_KILL: begin
                        if (state_q[tgt_tid] == FREE) cmd_err_d        = 1'b1;
                        else                          state_d[tgt_tid] = FREE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // State registers; reset wins over any concurrent command or stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_THD; i++) state_q[i] <= (i == 0) ? READY : FREE;
            ptr_q     <= TID_W'(NUM_THD - 1);
            new_vld_q <= 1'b0;
            new_tid_q <= '0;
            new_pc_q  <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_THD; i++) state_q[i] <= state_d[i];
            ptr_q     <= ptr_d;
            new_vld_q <= new_vld_d;
            new_tid_q <= new_tid_d;
            new_pc_q  <= new_pc_d;
            cmd_err_q <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_thread_scheduler.sv
// Scoreboard bench: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_thread_scheduler;
    import thd_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, stall, cmd_vld, init;
    logic [2:0]  cmd_tid, tgt_tid;
    logic [1:0]  trd_ctrl;
    logic [31:0] init_pc;
    logic        issue_vld, init_ok, new_vld, cmd_err, all_idle;
    logic [2:0]  issue_tid, init_tid, new_tid;
    logic [31:0] new_pc;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    typedef struct { logic v; logic [2:0] t; logic idle; } iss_t;
    typedef struct { logic ok; logic [2:0] t; bit chk_tid; } ini_t;
    typedef struct { int cyc; logic [2:0] t; logic [31:0] pc; } new_t;

    iss_t iss_q[$];
    ini_t ini_q[$];
    new_t new_q[$];
    int   err_q[$];

    thread_scheduler #(.NUM_THD(8)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .cmd_vld(cmd_vld), .cmd_tid(cmd_tid),
        .trd_ctrl(trd_ctrl), .init(init), .tgt_tid(tgt_tid), .init_pc(init_pc),
        .issue_vld(issue_vld), .issue_tid(issue_tid), .init_ok(init_ok), .init_tid(init_tid),
        .new_vld(new_vld), .new_tid(new_tid), .new_pc(new_pc), .cmd_err(cmd_err),
        .all_idle(all_idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (iss_q.size() > 0) begin
                iss_t e;
                e = iss_q.pop_front();
                checks++;
                if (issue_vld !== e.v || issue_tid !== e.t || all_idle !== e.idle) begin
                    errors++;
                    $display("FAIL issue cyc=%0d got vld=%b tid=%0d idle=%b want vld=%b tid=%0d idle=%b",
                             cyc_n, issue_vld, issue_tid, all_idle, e.v, e.t, e.idle);
                end
            end
            if (cmd_vld && init) begin
                checks++;
                if (ini_q.size() == 0) begin
                    errors++;
                    $display("FAIL init cyc=%0d no expectation queued", cyc_n);
                end else begin
                    ini_t e;
                    e = ini_q.pop_front();
                    if (init_ok !== e.ok || (e.chk_tid && init_tid !== e.t)) begin
                        errors++;
                        $display("FAIL init cyc=%0d got ok=%b tid=%0d want ok=%b tid=%0d",
                                 cyc_n, init_ok, init_tid, e.ok, e.t);
                    end
                end
            end
            if (new_vld) begin
                checks++;
                if (new_q.size() == 0 || new_q[0].cyc != cyc_n) begin
                    errors++;
                    $display("FAIL new_pulse cyc=%0d unexpected tid=%0d pc=%h", cyc_n, new_tid, new_pc);
                end else begin
                    new_t e;
                    e = new_q.pop_front();
                    if (new_tid !== e.t || new_pc !== e.pc) begin
                        errors++;
                        $display("FAIL new_pulse cyc=%0d got tid=%0d pc=%h want tid=%0d pc=%h",
                                 cyc_n, new_tid, new_pc, e.t, e.pc);
                    end
                end
            end
            if (new_q.size() > 0 && new_q[0].cyc < cyc_n) begin
                checks++; errors++;
                $display("FAIL new_pulse missing at cyc=%0d got 0 want 1", new_q[0].cyc);
                void'(new_q.pop_front());
            end
            if (cmd_err) begin
                checks++;
                if (err_q.size() == 0 || err_q[0] != cyc_n) begin
                    errors++;
                    $display("FAIL cmd_err cyc=%0d got 1 want 0", cyc_n);
                end else begin
                    void'(err_q.pop_front());
                end
            end
            if (err_q.size() > 0 && err_q[0] < cyc_n) begin
                checks++; errors++;
                $display("FAIL cmd_err missing at cyc=%0d got 0 want 1", err_q[0]);
                void'(err_q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] ct, input logic [1:0] trd,
                         input logic ini, input logic [2:0] tg, input logic [31:0] pc,
                         input logic stl);
        cmd_vld = v; cmd_tid = ct; trd_ctrl = trd; init = ini;
        tgt_tid = tg; init_pc = pc; stall = stl;
    endtask

    task automatic nop();                            drive(0, 0, TRD_NONE, 0, 0, 0, 0);  endtask
    task automatic c_sleep(input logic [2:0] t);     drive(1, t, TRD_SLEEP, 0, 0, 0, 0); endtask
    task automatic c_wake(input logic [2:0] t);      drive(1, 0, TRD_WAKE, 0, t, 0, 0);  endtask
    task automatic c_kill(input logic [2:0] c, input logic [2:0] t); drive(1, c, TRD_KILL, 0, t, 0, 0); endtask
    task automatic c_init(input logic [31:0] pc);    drive(1, 0, TRD_NONE, 1, 0, pc, 0); endtask

    task automatic exp_init(input logic ok, input logic [2:0] t, input bit chk);
        ini_q.push_back('{ok, t, chk});
    endtask
    task automatic exp_new(input logic [2:0] t, input logic [31:0] pc);
        new_q.push_back('{cyc_n + 1, t, pc});
    endtask
    task automatic exp_err();
        err_q.push_back(cyc_n + 1);
    endtask

    // Queue the expected issue outputs for this cycle, then advance one clock.
    task automatic tick(input logic v, input logic [2:0] t, input logic idle);
        iss_q.push_back('{v, t, idle});
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Only thread 0 live after reset.
        repeat (3) tick(1, 0, 0);

        // Three inits from thread 0.
        c_init(32'h100); exp_init(1, 1, 1); exp_new(1, 32'h100); tick(1, 0, 0);
        c_init(32'h200); exp_init(1, 2, 1); exp_new(2, 32'h200); tick(1, 1, 0);
        c_init(32'h300); exp_init(1, 3, 1); exp_new(3, 32'h300); tick(1, 2, 0);
        nop(); tick(1, 3, 0); tick(1, 0, 0); tick(1, 1, 0); tick(1, 2, 0);

        // Thread 2 sleeps, rotation skips it, then wake.
        c_sleep(2); tick(1, 3, 0);
        nop(); tick(1, 0, 0); tick(1, 1, 0); tick(1, 3, 0); tick(1, 0, 0);
        c_wake(2); tick(1, 1, 0);
        nop(); tick(1, 2, 0); tick(1, 3, 0); tick(1, 0, 0);
        c_wake(5); exp_err(); tick(1, 1, 0);
        drive(1, 0, TRD_WAKE, 1, 5, 0, 0); exp_init(0, 0, 0); exp_err(); tick(1, 2, 0);

        // Stall holds the pointer.
        drive(0, 0, TRD_NONE, 0, 0, 0, 1);
        repeat (4) tick(1, 3, 0);
        nop(); tick(1, 3, 0);
        c_wake(1); tick(1, 0, 0);
        nop(); tick(1, 1, 0);

        // Fill remaining slots, overflow, self-kill, reuse.
        c_init(32'h400); exp_init(1, 4, 1); exp_new(4, 32'h400); tick(1, 2, 0);
        c_init(32'h500); exp_init(1, 5, 1); exp_new(5, 32'h500); tick(1, 3, 0);
        c_init(32'h600); exp_init(1, 6, 1); exp_new(6, 32'h600); tick(1, 4, 0);
        c_init(32'h700); exp_init(1, 7, 1); exp_new(7, 32'h700); tick(1, 5, 0);
        c_init(32'h800); exp_init(0, 0, 1); exp_err(); tick(1, 6, 0);
        c_kill(3, 3); tick(1, 7, 0);
        c_init(32'h333); exp_init(1, 3, 1); exp_new(3, 32'h333); tick(1, 0, 0);
        nop(); tick(1, 1, 0);

        // Tear down every thread.
        for (int i = 1; i < 8; i++) begin
            c_kill(0, 3'(i));
            tick(1, (i < 7) ? 3'(i + 1) : 3'd0, 0);
        end
        c_kill(0, 0); tick(1, 0, 0);
        c_sleep(2); exp_err(); tick(0, 0, 1);
        c_kill(0, 5); exp_err(); tick(0, 0, 1);
        nop(); tick(0, 0, 1);

        // Reset during a wake to a FREE thread and a stall.
        rst_n = 1'b0;
        drive(1, 0, TRD_WAKE, 0, 0, 0, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nop();
        tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);

        // Anything left unconsumed is a missed output.
        checks++;
        if (iss_q.size() + ini_q.size() + new_q.size() + err_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d/%0d/%0d pending want 0",
                     iss_q.size(), ini_q.size(), new_q.size(), err_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/thread_scheduler.md
Name: thread_scheduler

Overview:
- Owns the per-thread state table of the multithreaded core and picks the thread that fetches/issues each cycle, round-robin among ready threads.
- Consumes the thread-control fields produced by the decoder: the 2-bit trd_ctrl (01 sleep, 10 wake, 11 kill) and the init flag.
- Returns the thread ID allocated on init to the decode/write-back path.
- Sits between decode and fetch.

Parameters:
- NUM_THD, 8, number of hardware threads (power of two, 2..32).
- TID_W, $clog2(NUM_THD), thread ID width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  pipeline stall; holds the round-robin pointer.
- cmd_vld  in  1  a decoded thread instruction commits this cycle.
- cmd_tid  in  TID_W  thread executing the command.
- trd_ctrl  in  2  00 none, 01 sleep, 10 wake, 11 kill.
- init  in  1  allocate a new thread (exclusive with a nonzero trd_ctrl).
- tgt_tid  in  TID_W  target thread for wake/kill (low TID_W bits of operand A).
- init_pc  in  32  start PC for the new thread.
- issue_vld  out  1  issue_tid is valid.
- issue_tid  out  TID_W  thread selected this cycle.
- init_ok  out  1  init succeeded (combinational, qualified by cmd_vld&init).
- init_tid  out  TID_W  allocated thread ID (write-back data).
- new_vld  out  1  one-cycle pulse: new thread started; load its PC.
- new_tid  out  TID_W  thread whose PC is loaded.
- new_pc  out  32  PC to load.
- cmd_err  out  1  one-cycle pulse: illegal command ignored.
- all_idle  out  1  no thread is READY or SLEEP.

Behaviour:
- Reset behaviour:
  - One clock; reset is synchronous and active-low (rst_n, sampled on posedge clk).
  - State per thread: FREE, READY or SLEEP. Reset puts thread 0 in READY and all others in FREE.
  - Round-robin pointer resets to NUM_THD-1, so thread 0 is granted first.
  - new_vld, cmd_err and the pointer are registered and all reset to 0 (pointer to NUM_THD-1).
  - Immediately after reset: issue_vld=1, issue_tid=0, all_idle=0.
- Grant logic:
  - Combinational from the current state registers: the first READY thread strictly after the pointer, wrapping modulo NUM_THD.
  - The pointer itself is eligible last.
  - issue_vld=0 and issue_tid=0 when no thread is READY.
- Pointer update: on a posedge with issue_vld=1 and stall=0, the pointer takes issue_tid. stall=1 holds the pointer.
- Command latency:
  - Commands are sampled when cmd_vld=1 and update the state table at the same edge.
  - The effect is visible to the grant logic on the next cycle, i.e. 1-cycle latency.
- Sleep: thread cmd_tid goes READY->SLEEP. If cmd_tid is not READY, raise cmd_err and leave state unchanged.
- Wake:
  - tgt_tid in SLEEP -> READY.
  - tgt_tid already READY: no-op, no error.
  - tgt_tid FREE: cmd_err.
- Kill:
  - tgt_tid in READY or SLEEP -> FREE. Killing itself (tgt_tid==cmd_tid) is legal.
  - tgt_tid already FREE: cmd_err.
- Init:
  - init_tid is the lowest-indexed FREE thread; init_ok=1 if one exists.
  - On success, at the edge: that thread becomes READY. The next cycle drives new_vld=1 with new_tid=init_tid and new_pc=init_pc (registered).
  - No FREE thread: init_ok=0, init_tid=0, cmd_err pulses, no state change.
- Priority: one command per cycle, so there are no intra-cycle conflicts. A command never changes any thread other than its single subject.
- all_idle = no thread is READY or SLEEP. When all_idle=1, issue_vld=0 and the state persists until reset.
- Illegal encodings: cmd_vld with init=1 and trd_ctrl!=0 → cmd_err, no state change.
- Reset mid-operation: synchronous reset overrides any concurrent command or stall on the same edge.

Decomposition:
- Package thd_pkg holds:
  - thd_state_e (FREE=2'b00, READY=2'b01, SLEEP=2'b10).
  - Encodings TRD_SLEEP/TRD_WAKE/TRD_KILL matching the decoder's trd_ctrl.
  - NUM_THD_DEF.
- One sub-module, rr_arbiter (parameter N), takes a request vector plus the pointer and returns grant valid and index.
- Reuse rr_arbiter for any future requester sharing.

Test Plan:
- Reset release: only thread 0 ready → issue_tid=0 on every cycle, issue_vld=1, all_idle=0.
- Init ×3 from thread 0 with init_pc=0x100/0x200/0x300:
  - init_tid responds 1, 2, 3.
  - new_vld pulses carry matching PCs one cycle later.
  - issue then rotates 0,1,2,3,0…
- Thread 2 sleeps:
  - Next cycle the rotation is 0,1,3.
  - Thread 0 wakes tgt_tid=2 → 2 rejoins the rotation after 1 cycle.
  - Waking thread 5 (FREE) → cmd_err=1 for one cycle.
- stall=1 for 4 cycles with threads 0..3 ready → issue_tid stays constant. After release the rotation continues from that thread's successor.
- Fill all 8 threads, then init again → init_ok=0, cmd_err=1, states unchanged. Thread 3 kills itself → init_tid=3 on the next init.
- Kill threads 1..7, then thread 0 kills itself → issue_vld=0, all_idle=1. Assert rst_n=0 during a concurrent wake → thread 0 READY after reset.
